fb_line_writer: RTL and testbench

- Write-side producer for the triple-buffered framebuffer controller.
- Takes one line segment per command: two endpoints plus a 4-bit colour. Rasterises it with integer Bresenham, one point per cycle, and drives the framebuffer write port (w_addr, color_in, en_w).
- Sits between the vector generator and the framebuffer. Replaces ad-hoc pixel writes with a clipped, handshaked line stream.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_addr_calc.sv | 21 ++
 rtl/fb_line_writer.sv | 154 +++++++++++++++
 tb/tb_fb_line_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and line-rasteriser state encoding.
// Contents: H_PIXELS/V_PIXELS screen size, FB_ADDR_W linear address width,
// line_state_t for the line writer FSM. Also used by the framebuffer controller.
package fb_pkg;

  localparam int H_PIXELS  = 640;
  localparam int V_PIXELS  = 480;
  localparam int FB_ADDR_W = 19;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address: row*640 + col, built from shifts and adds.
// Latency: combinational. No flow control.
// Ports: row (9b), col (10b) in; addr (FB_ADDR_W) out.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [Y_W-1:0]       row,
  input  logic [X_W-1:0]       col,
  output logic [FB_ADDR_W-1:0] addr
);

  logic [FB_ADDR_W-1:0] row_ext;
  logic [FB_ADDR_W-1:0] col_ext;

  assign row_ext = {{(FB_ADDR_W-Y_W){1'b0}}, row};
  assign col_ext = {{(FB_ADDR_W-X_W){1'b0}}, col};

  // 640 = 512 + 128
  assign addr = (row_ext << 9) + (row_ext << 7) + col_ext;

endmodule

// File: rtl/fb_line_writer.sv
// Bresenham line rasteriser feeding the framebuffer write port, one point/cycle.
// Latency: start sampled at edge 0, first write visible in cycle 3 (registered output).
// Backpressure: hold freezes stepping; no point is emitted while hold is high.
// Ports: clk, rst (async active-low); start, x0, y0, x1, y1, color, hold in;
//        busy, done, w_addr, color_out, en_w out.
module fb_line_writer #(
  parameter int H_PIXELS = fb_pkg::H_PIXELS,
  parameter int V_PIXELS = fb_pkg::V_PIXELS,
  parameter int ADDR_W   = fb_pkg::FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        x1,
  input  logic [8:0]        y1,
  input  logic [3:0]        color,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [3:0]        color_out,
  output logic              en_w
);

  import fb_pkg::*;

  line_state_t state;

  logic [9:0]        cx;
  logic [8:0]        cy;
  logic [9:0]        x1_r;
  logic [8:0]        y1_r;
  logic [3:0]        col_r;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] err;
  logic              sx_neg;
  logic              sy_neg;

  // Setup arithmetic on the latched endpoints (cx/cy hold x0/y0 here)
  logic signed [11:0] xd;
  logic signed [11:0] yd;
  logic signed [11:0] adx;
  logic signed [11:0] ady;

  assign xd  = $signed({2'b00, x1_r}) - $signed({2'b00, cx});
  assign yd  = $signed({3'b000, y1_r}) - $signed({3'b000, cy});
  assign adx = xd[11] ? -xd : xd;
  assign ady = yd[11] ? -yd : yd;

  // Bresenham step decision from err at the start of the cycle
  logic signed [12:0] e2;
  logic signed [12:0] dx_ext;
  logic signed [12:0] dy_ext;
  logic               step_x;
  logic               step_y;
  logic signed [11:0] err_nxt;
  logic               at_end;
  logic               emit;
  logic               in_bounds;

  assign e2      = {err, 1'b0};
  assign dx_ext  = {dx[11], dx};
  assign dy_ext  = {dy[11], dy};
  assign step_x  = (e2 >= dy_ext);
  assign step_y  = (e2 <= dx_ext);
  assign err_nxt = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
  assign at_end  = (cx == x1_r) && (cy == y1_r);
  assign emit    = (state == DRAW) && !hold;

  // Off-screen points still step but never write
  assign in_bounds = (int'(cx) < H_PIXELS) && (int'(cy) < V_PIXELS);

  logic [FB_ADDR_W-1:0] addr_nxt;

  fb_addr_calc u_addr_calc (
    .row  (cy),
    .col  (cx),
    .addr (addr_nxt)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      x1_r   <= '0;
      y1_r   <= '0;
      col_r  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cx    <= x0;
            cy    <= y0;
            x1_r  <= x1;
            y1_r  <= y1;
            col_r <= color;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx     <= adx;
          dy     <= -ady;
          err    <= adx - ady;
          sx_neg <= (xd <= 12'sd0);
          sy_neg <= (yd <= 12'sd0);
          state  <= DRAW;
        end
        DRAW: begin
          if (!hold) begin
            if (at_end) begin
              state <= DONE;
            end else begin
              err <= err_nxt;
              if (step_x) cx <= sx_neg ? cx - 10'd1 : cx + 10'd1;
              if (step_y) cy <= sy_neg ? cy - 9'd1 : cy + 9'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: one register between the rasteriser and the write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_w      <= 1'b0;
      w_addr    <= '0;
      color_out <= '0;
    end else if (emit) begin
      en_w      <= in_bounds;
      w_addr    <= ADDR_W'(addr_nxt);
      color_out <= col_r;
    end else begin
      en_w      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_line_writer.sv
// Self-checking bench for fb_line_writer: directed lines with hand-computed
// addresses/cycles pushed to a queue, popped by a monitor on every en_w/done.
module tb_fb_line_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0;
  logic [8:0]  y0 = '0;
  logic [9:0]  x1 = '0;
  logic [8:0]  y1 = '0;
  logic [3:0]  color = '0;
  logic        hold = 1'b0;
  logic        busy;
  logic        done;
  logic [18:0] w_addr;
  logic [3:0]  color_out;
  logic        en_w;

  fb_line_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .color     (color),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .w_addr    (w_addr),
    .color_out (color_out),
    .en_w      (en_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        en;
    logic [18:0] addr;
    logic [3:0]  col;
    logic        dn;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   mon_n;
  int   tests = 0;
  int   fails = 0;
  int   t0 = 0;

  // Monitor: every cycle with a write or done must match the next expectation
  always @(negedge clk) begin
    if (rst && (en_w || done)) begin
      tests++;
      mon_n = cyc - t0 + 1;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: en_w=%0d done=%0d w_addr=%0d cycle=%0d, required no output",
                 en_w, done, w_addr, mon_n);
      end else begin
        mon_e = q.pop_front();
        if (en_w !== mon_e.en || done !== mon_e.dn || mon_n != mon_e.cyc ||
            (mon_e.en && (w_addr !== mon_e.addr || color_out !== mon_e.col))) begin
          fails++;
          $display("FAIL out_point: got en_w=%0d done=%0d w_addr=%0d color=%0d cycle=%0d, required en_w=%0d done=%0d w_addr=%0d color=%0d cycle=%0d",
                   en_w, done, w_addr, color_out, mon_n,
                   mon_e.en, mon_e.dn, mon_e.addr, mon_e.col, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic en, input int addr, input logic [3:0] col,
                      input logic dn, input int c);
    exp_t e;
    e.en   = en;
    e.addr = addr[18:0];
    e.col  = col;
    e.dn   = dn;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic issue(input logic [9:0] a0, input logic [8:0] b0,
                       input logic [9:0] a1, input logic [8:0] b1,
                       input logic [3:0] c);
    @(negedge clk);
    x0 = a0; y0 = b0; x1 = a1; y1 = b1; color = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  // Advance to 1ns into cycle n of the current line
  task automatic goto_cycle(input int n);
    while (cyc - t0 + 1 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    tests++;
    if (k >= 100) begin
      fails++;
      $display("FAIL %s_timeout: %0d expected outputs still pending, busy=%0d", name, q.size(), busy);
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en_w", en_w, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_color_out", color_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Horizontal (0,0)->(3,0) colour 5
    for (int i = 0; i < 4; i++) push(1'b1, i, 4'd5, i == 3, 3 + i);
    issue(10'd0, 9'd0, 10'd3, 9'd0, 4'd5);
    chk("horiz_busy_c1", busy, 1);
    goto_cycle(6);
    chk("horiz_busy_c6", busy, 1);
    goto_cycle(7);
    chk("horiz_busy_c7", busy, 0);
    drain("horiz");

    // Vertical (10,2)->(10,4)
    push(1'b1, 1290, 4'd7, 1'b0, 3);
    push(1'b1, 1930, 4'd7, 1'b0, 4);
    push(1'b1, 2570, 4'd7, 1'b1, 5);
    issue(10'd10, 9'd2, 10'd10, 9'd4, 4'd7);
    drain("vert");

    // Reverse diagonal (3,3)->(0,0)
    push(1'b1, 1923, 4'd3, 1'b0, 3);
    push(1'b1, 1282, 4'd3, 1'b0, 4);
    push(1'b1,  641, 4'd3, 1'b0, 5);
    push(1'b1,    0, 4'd3, 1'b1, 6);
    issue(10'd3, 9'd3, 10'd0, 9'd0, 4'd3);
    drain("rdiag");

    // Single point at the last pixel
    push(1'b1, 307199, 4'hF, 1'b1, 3);
    issue(10'd639, 9'd479, 10'd639, 9'd479, 4'hF);
    goto_cycle(4);
    chk("single_busy_c4", busy, 0);
    drain("single");

    // Clipped tail: 640 and 641 are off-screen, done lands on a clipped point
    push(1'b1, 638, 4'd2, 1'b0, 3);
    push(1'b1, 639, 4'd2, 1'b0, 4);
    push(1'b0,   0, 4'd2, 1'b1, 6);
    issue(10'd638, 9'd0, 10'd641, 9'd0, 4'd2);
    goto_cycle(7);
    chk("clip_busy_c7", busy, 0);
    drain("clip");

    // Hold for 3 cycles after the 2nd point, plus a start pulse while busy
    push(1'b1, 0, 4'd9, 1'b0, 3);
    push(1'b1, 1, 4'd9, 1'b0, 4);
    push(1'b1, 2, 4'd9, 1'b0, 8);
    push(1'b1, 3, 4'd9, 1'b0, 9);
    push(1'b1, 4, 4'd9, 1'b1, 10);
    issue(10'd0, 9'd0, 10'd4, 9'd0, 4'd9);
    goto_cycle(4);
    hold = 1'b1;
    goto_cycle(5);
    x0 = 10'd100; y0 = 9'd100; x1 = 10'd101; y1 = 9'd100; color = 4'd1;
    start = 1'b1;
    goto_cycle(6);
    start = 1'b0;
    goto_cycle(7);
    hold = 1'b0;
    goto_cycle(10);
    chk("hold_busy_c10", busy, 1);
    goto_cycle(11);
    chk("hold_busy_c11", busy, 0);
    drain("hold");

    // Mid-line reset during the 3rd pixel of (0,0)->(9,0)
    push(1'b1, 0, 4'd4, 1'b0, 3);
    push(1'b1, 1, 4'd4, 1'b0, 4);
    push(1'b1, 2, 4'd4, 1'b0, 5);
    issue(10'd0, 9'd0, 10'd9, 9'd0, 4'd4);
    goto_cycle(5);
    @(negedge clk);
    #1;
    chk("mid_en_w_before", en_w, 1);
    rst = 1'b0;
    #1;
    chk("mid_en_w_async", en_w, 0);
    chk("mid_busy_async", busy, 0);
    chk("mid_done_async", done, 0);
    chk("mid_w_addr_async", w_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy_after", busy, 0);
    drain("midrst");

    // Fresh line after reset starts from its own x0
    push(1'b1, 645, 4'd6, 1'b0, 3);
    push(1'b1, 646, 4'd6, 1'b1, 4);
    issue(10'd5, 9'd1, 10'd6, 9'd1, 4'd6);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
